// File: rtl/de2_pio_pkg.sv
// Shared definitions for the DE2 input PIO: register map, edge-type encodings
// and the edge-detect helper used by the top level.
package de2_pio_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_RSVD     = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

   typedef enum int {
      EDGE_RISE = 0,
      EDGE_FALL = 1,
      EDGE_ANY  = 2
   } edge_type_e;

   // Edge vector between the current filtered level and the previous one.
   function automatic logic [31:0] edge_vec(input int etype,
                                            input logic [31:0] cur,
                                            input logic [31:0] prv);
      logic [31:0] res;
      case (etype)
         int'(EDGE_RISE): res = cur & ~prv;
         int'(EDGE_FALL): res = ~cur & prv;
         default:         res = cur ^ prv;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/de2_pio_button_in_if.sv
// Avalon-MM slave bus bundle for the input PIO (2-bit word address, 1-cycle read
// latency); the CPU side uses master, the PIO uses slave.
interface de2_pio_button_in_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/de2_pio_debounce.sv
// One-bit debounce filter: the output follows the input only after it has
// differed from the output for DEBOUNCE_CYCLES consecutive cycles.
module de2_pio_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_BIT        = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (din == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         filt_d = din;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         filt_q <= IDLE_BIT;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign dout = filt_q;

endmodule

// File: rtl/de2_pio_button_in.sv
// Avalon-MM input PIO for DE2 keys/switches: sync, optional debounce (macro
// PIO_IN_DEBOUNCE_EN), sticky edge capture with W1C and a maskable level irq.
module de2_pio_button_in
   import de2_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter logic [WIDTH-1:0] IDLE_VALUE      = WIDTH'(4'hF),
   parameter int               EDGE_TYPE       = 1,
   parameter int               DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   de2_pio_button_in_if.slave   bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   logic [WIDTH-1:0] sync_q1, sync_d1;
   logic [WIDTH-1:0] sync_q2, sync_d2;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [31:0]      rdata_q, rdata_d;

   logic [WIDTH-1:0] filtered;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] clr;
   logic             wr_en;
   logic             unused_wdata;

`ifdef PIO_IN_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      de2_pio_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_BIT        (IDLE_VALUE[i])
      ) u_db (
         .clk   (clk),
         .reset (reset),
         .din   (sync_q2[i]),
         .dout  (filtered[i])
      );
   end
`else
   localparam int UNUSED_DEBOUNCE = DEBOUNCE_CYCLES;
   assign filtered = sync_q2;
`endif

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign edges        = WIDTH'(edge_vec(EDGE_TYPE, 32'(filtered), 32'(prev_q)));
   assign unused_wdata = ^bus.writedata;

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      sync_d1 = in_port;
      sync_d2 = sync_q1;
      prev_d  = filtered;

      mask_d = mask_q;
      if (wr_en && bus.address == ADDR_IRQ_MASK) begin
         mask_d = bus.writedata[WIDTH-1:0];
      end

      clr = '0;
      if (wr_en && bus.address == ADDR_EDGE_CAP) begin
         clr = bus.writedata[WIDTH-1:0];
      end
      // A new edge wins over a simultaneous clear of the same bit.
      cap_d = (cap_q & ~clr) | edges;

      // Mux reads the pre-write register values, so a same-cycle write is not seen.
      rdata_d = '0;
      case (bus.address)
         ADDR_DATA:     rdata_d[WIDTH-1:0] = filtered;
         ADDR_IRQ_MASK: rdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGE_CAP: rdata_d[WIDTH-1:0] = cap_q;
         default:       rdata_d = '0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge value of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= IDLE_VALUE;
         sync_q2 <= IDLE_VALUE;
         prev_q  <= IDLE_VALUE;
         cap_q   <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
      end else begin
         sync_q1 <= sync_d1;
         sync_q2 <= sync_d2;
         prev_q  <= prev_d;
         cap_q   <= cap_d;
         mask_q  <= mask_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_de2_pio_button_in.sv
// Scoreboard bench for de2_pio_button_in (WIDTH 4, idle 0xF, falling edges);
// reads push expectations, a monitor checks readdata/irq one cycle later.
module tb_de2_pio_button_in;

   localparam int DB     = 8;
`ifdef PIO_IN_DEBOUNCE_EN
   localparam int SETTLE = DB + 5;
`else
   localparam int SETTLE = 3;
`endif

   typedef struct {
      logic [31:0] data;
      logic        irq;
      int          tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_port;
   logic       irq;

   de2_pio_button_in_if bus_if ();

   de2_pio_button_in #(
      .WIDTH           (4),
      .IDLE_VALUE      (4'hF),
      .EDGE_TYPE       (1),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_if),
      .in_port (in_port),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];

   // Transaction-level model of what software should observe.
   logic [3:0] model_lvl;
   logic [3:0] model_cap;
   logic [3:0] model_mask;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic model_irq();
      return |(model_cap & model_mask);
   endfunction

   // Monitor: a read presented at posedge P returns readdata after P.
   logic rd_valid = 1'b0;
   always @(posedge clk) rd_valid <= bus_if.chipselect && bus_if.write_n;

   always @(negedge clk) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("rd_data_%0d", e.tag), bus_if.readdata, e.data);
            check($sformatf("rd_irq_%0d", e.tag), {31'd0, irq}, {31'd0, e.irq});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      bus_if.address    = addr;
      bus_if.writedata  = data;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] addr, input logic [31:0] exp_data, input int tag);
      exp_t e;
      e.data = exp_data;
      e.irq  = model_irq();
      e.tag  = tag;
      exp_q.push_back(e);
      bus_if.address    = addr;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b1;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
   endtask

   task automatic wr_mask(input logic [31:0] data);
      wr(2'd2, data);
      model_mask = data[3:0];
   endtask

   task automatic wr_clr(input logic [31:0] data);
      wr(2'd3, data);
      model_cap = model_cap & ~data[3:0];
   endtask

   // Falling-edge capture rule: every bit that goes 1 -> 0 becomes pending.
   task automatic set_input(input logic [3:0] v);
      in_port   = v;
      model_cap = model_cap | (model_lvl & ~v);
      model_lvl = v;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      in_port = 4'hF;
      tick(3);
      reset   = 1'b0;
      model_lvl  = 4'hF;
      model_cap  = 4'h0;
      model_mask = 4'h0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'd0;
      @(negedge clk);
      do_reset();

      // Reset state
      check("irq_after_reset", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'h0000_000F, 1);
      rd(2'd1, 32'h0, 2);
      rd(2'd2, 32'h0, 3);
      rd(2'd3, 32'h0, 4);

`ifndef PIO_IN_DEBOUNCE_EN
      // Exact latency: change before E0, capture at E2
      wr_mask(32'h1);
      set_input(4'hE);
      tick(1);
      check("lat_e0_irq", {31'd0, irq}, 32'd0);
      tick(1);
      check("lat_e1_irq", {31'd0, irq}, 32'd0);
      tick(1);
      check("lat_e2_irq", {31'd0, irq}, 32'd1);
      rd(2'd3, 32'h1, 10);
      rd(2'd0, 32'hE, 11);
      wr_clr(32'h1);
      check("rd_during_w1c", bus_if.readdata, 32'h1);
      check("irq_after_w1c", {31'd0, irq}, 32'd0);
`endif

      // Two pending edges, partial clear
      set_input(4'hF);
      tick(SETTLE);
      wr_mask(32'h3);
      set_input(4'hC);
      tick(SETTLE);
      rd(2'd3, 32'h3, 20);
      wr_clr(32'h2);
      rd(2'd3, 32'h1, 21);
      wr_clr(32'h1);
      rd(2'd3, 32'h0, 22);

`ifndef PIO_IN_DEBOUNCE_EN
      // Edge and W1C of the same bit in the same cycle: set wins
      set_input(4'hF);
      tick(SETTLE);
      set_input(4'hE);
      tick(2);
      wr(2'd3, 32'h1);
      rd(2'd3, 32'h1, 30);
      wr_clr(32'hF);
`endif

      // Unmasking an already pending bit
      wr_mask(32'h0);
      set_input(4'hF);
      tick(SETTLE);
      set_input(4'hB);
      tick(SETTLE);
      check("irq_masked", {31'd0, irq}, 32'd0);
      wr_mask(32'h4);
      check("irq_unmask", {31'd0, irq}, 32'd1);
      rd(2'd2, 32'h4, 40);
      wr_mask(32'hFFFF_FFF0);
      rd(2'd2, 32'h0, 41);
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1, 32'h0, 42);
      wr_clr(32'hF);
      rd(2'd3, 32'h0, 43);

      // Reset mid-operation drops pending edges
      wr_mask(32'hF);
      set_input(4'hA);
      tick(SETTLE);
      check("irq_before_reset", {31'd0, irq}, 32'd1);
      do_reset();
      check("irq_after_reset2", {31'd0, irq}, 32'd0);
      tick(SETTLE);
      rd(2'd3, 32'h0, 50);
      rd(2'd0, 32'hF, 51);

`ifdef PIO_IN_DEBOUNCE_EN
      // Short bounce is rejected, long hold is accepted
      in_port = 4'hE;
      tick(5);
      in_port = 4'hF;
      tick(SETTLE);
      rd(2'd3, 32'h0, 60);
      rd(2'd0, 32'hF, 61);
      set_input(4'hE);
      tick(20);
      rd(2'd3, 32'h1, 62);
      rd(2'd0, 32'hE, 63);
      wr_clr(32'hF);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] r;
         set_input(4'($urandom_range(0, 15)));
         tick(SETTLE + int'($urandom_range(0, 2)));
         r = $urandom;
         case ($urandom_range(0, 3))
            0: rd(2'd0, {28'd0, model_lvl}, 100 + i);
            1: rd(2'd3, {28'd0, model_cap}, 100 + i);
            2: begin
               wr_mask(r);
               rd(2'd2, {28'd0, model_mask}, 100 + i);
            end
            default: begin
               wr_clr(r);
               rd(2'd3, {28'd0, model_cap}, 100 + i);
            end
         endcase
      end

      tick(3);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
